// File: rtl/bcd_seg_scanner.sv
// Scans a snapshotted multi-digit BCD value onto one active-low 7-segment bus,
// one digit at a time, with leading-zero blanking and a '-' glyph for codes 10-15.
module bcd_seg_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int LZ_BLANK    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    load,
    input  logic                    en,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    scan_tick
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]       SEG_OFF  = 7'h7F;

    logic [4*NUM_DIGITS-1:0] snap;
    logic [PRE_W-1:0]        presc_left;
    logic [IDX_W-1:0]        idx;
    logic                    presc_tc;
    logic [3:0]              cur_digit;
    logic                    upper_zero;
    logic                    run_zero;
    logic                    blank_digit;
    logic [NUM_DIGITS-1:0]   an_next;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    // presc_left holds the cycles still to go on the current digit; the
    // terminal count (0) is the last enabled cycle before idx moves on.
    assign presc_tc = (presc_left == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            snap       <= '0;
            presc_left <= PRE_LAST;
            idx        <= '0;
            scan_tick  <= 1'b0;
        end else begin
            if (load) begin
                snap <= bcd_in;
            end
            scan_tick <= en && presc_tc;
            if (en) begin
                if (presc_tc) begin
                    presc_left <= PRE_LAST;
                    idx        <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end else begin
                    presc_left <= presc_left - 1'b1;
                end
            end
        end
    end

    // Walk digits from the top down so the zero run above idx is known
    // at the moment the selected digit is reached.
    always_comb begin
        run_zero   = 1'b1;
        cur_digit  = 4'h0;
        upper_zero = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run_zero = run_zero & (snap[4*i +: 4] == 4'h0);
            if (idx == IDX_W'(i)) begin
                cur_digit  = snap[4*i +: 4];
                upper_zero = run_zero;
            end
        end
    end

    assign blank_digit = (LZ_BLANK != 0) && (idx != '0) && upper_zero;

    always_comb begin
        an_next = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_next[i] = (idx != IDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            an  <= '1;
            seg <= SEG_OFF;
        end else if (!en || blank_digit) begin
            an  <= '1;
            seg <= SEG_OFF;
        end else begin
            an  <= an_next;
            seg <= decode(cur_digit);
        end
    end

endmodule
